// File: rtl/mod_n_counter.sv
// Modulo-N up-counter clocked by incr_i, with asynchronous active-low clear.
// count_o steps 0..N-1 and wraps to 0. wrap_o flags that the next enabled edge wraps.
module mod_n_counter #(
    parameter int unsigned N = 3,
    localparam int unsigned W = (N > 2) ? $clog2(N) : 1
) (
    input  logic         incr_i,
    input  logic         clear_ni,
    input  logic         en_i,
    output logic [W-1:0] count_o,
    output logic         wrap_o
);

    localparam int unsigned WE = W + 1;
    localparam logic [WE-1:0] N_EXT = WE'(N);

    logic [W-1:0]  r_count;
    logic [W-1:0]  w_count_next;
    logic [WE-1:0] w_inc;
    logic          w_at_last;
    logic          w_illegal;

    if (N < 2) begin : g_bad_n
        $fatal(1, "mod_n_counter: N must be >= 2");
    end

    // The increment is one bit wider so that N == 2**W compares without aliasing to 0.
    always_comb begin
        w_inc        = {1'b0, r_count} + WE'(1);
        w_at_last    = (w_inc == N_EXT);
        w_illegal    = ({1'b0, r_count} >= N_EXT);
        w_count_next = r_count;
        if (w_illegal) begin
            w_count_next = '0;
        end else if (en_i) begin
            w_count_next = w_at_last ? '0 : w_inc[W-1:0];
        end
    end

    always_ff @(posedge incr_i or negedge clear_ni) begin
        if (!clear_ni) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

    assign count_o = r_count;
    assign wrap_o  = en_i & w_at_last;

endmodule

// File: tb/tb_mod_n_counter.sv
// Directed self-checking bench for mod_n_counter: N=2,3,4,5,8 instances share clock, clear and enable.
module tb_mod_n_counter;

    logic       clk;
    logic       clear_n;
    logic       en;
    logic [0:0] c2;
    logic [1:0] c3;
    logic [1:0] c4;
    logic [2:0] c5;
    logic [2:0] c8;
    logic       w2, w3, w4, w5, w8;

    int n_tests;
    int n_fail;

    mod_n_counter #(.N(2)) u_n2 (.incr_i(clk), .clear_ni(clear_n), .en_i(en), .count_o(c2), .wrap_o(w2));
    mod_n_counter #(.N(3)) u_n3 (.incr_i(clk), .clear_ni(clear_n), .en_i(en), .count_o(c3), .wrap_o(w3));
    mod_n_counter #(.N(4)) u_n4 (.incr_i(clk), .clear_ni(clear_n), .en_i(en), .count_o(c4), .wrap_o(w4));
    mod_n_counter #(.N(5)) u_n5 (.incr_i(clk), .clear_ni(clear_n), .en_i(en), .count_o(c5), .wrap_o(w5));
    mod_n_counter #(.N(8)) u_n8 (.incr_i(clk), .clear_ni(clear_n), .en_i(en), .count_o(c8), .wrap_o(w8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        clear_n = 1'b0;
        en      = 1'b1;

        // Test 1: held in clear while the clock toggles
        #1;
        check("t1_c3_t1", 32'(c3), 0);
        check("t1_w3_t1", 32'(w3), 0);
        @(posedge clk); #1;
        check("t1_c3_edge", 32'(c3), 0);
        @(negedge clk);
        check("t1_c3_neg", 32'(c3), 0);
        check("t1_w3_neg", 32'(w3), 0);
        check("t1_c8_neg", 32'(c8), 0);

        // Width derivation
        check("w_n2", u_n2.W, 1);
        check("w_n4", u_n4.W, 2);
        check("w_n5", u_n5.W, 3);
        check("w_n8", u_n8.W, 3);

        // Tests 2 and 5: free-run, 20 edges, each instance follows k mod N
        clear_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            check($sformatf("t2_c3_k%0d", k), 32'(c3), k % 3);
            check($sformatf("t2_w3_k%0d", k), 32'(w3), ((k % 3) == 2) ? 1 : 0);
            check($sformatf("t5_c2_k%0d", k), 32'(c2), k % 2);
            check($sformatf("t5_w2_k%0d", k), 32'(w2), ((k % 2) == 1) ? 1 : 0);
            check($sformatf("t5_c4_k%0d", k), 32'(c4), k % 4);
            check($sformatf("t5_c5_k%0d", k), 32'(c5), k % 5);
            check($sformatf("t5_w5_k%0d", k), 32'(w5), ((k % 5) == 4) ? 1 : 0);
            check($sformatf("t5_c8_k%0d", k), 32'(c8), k % 8);
            check($sformatf("t5_w8_k%0d", k), 32'(w8), ((k % 8) == 7) ? 1 : 0);
        end
        check("t2_final", 32'(c3), 2);

        // Test 3: bring N=3 to 1, then hold with en low
        @(negedge clk);
        check("t3_c3_wrap0", 32'(c3), 0);
        @(negedge clk);
        check("t3_c3_one", 32'(c3), 1);
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("t3_hold_%0d", k), 32'(c3), 1);
        end
        check("t3_w3_hold", 32'(w3), 0);
        en = 1'b1;
        @(negedge clk);
        check("t3_c3_two", 32'(c3), 2);
        check("t3_w3_two", 32'(w3), 1);
        en = 1'b0;
        #1;
        check("t3_w3_en0", 32'(w3), 0);
        en = 1'b1;

        // Test 4: async clear between edges
        #1;
        clear_n = 1'b0;
        #1;
        check("t4_c3_async", 32'(c3), 0);
        check("t4_w3_async", 32'(w3), 0);
        @(posedge clk); #1;
        check("t4_c3_held", 32'(c3), 0);
        @(negedge clk);
        clear_n = 1'b1;
        @(negedge clk);
        check("t4_c3_after", 32'(c3), 1);

        // Test 6: illegal-state recovery on N=5, en low then en high
        en = 1'b0;
        @(negedge clk);
        force u_n5.r_count = 3'd6;
        #1;
        release u_n5.r_count;
        #1;
        check("t6_c5_forced", 32'(c5), 6);
        check("t6_w5_forced", 32'(w5), 0);
        @(negedge clk);
        check("t6_c5_rec_en0", 32'(c5), 0);
        en = 1'b1;
        force u_n5.r_count = 3'd6;
        #1;
        release u_n5.r_count;
        @(negedge clk);
        check("t6_c5_rec_en1", 32'(c5), 0);
        @(negedge clk);
        check("t6_c5_next", 32'(c5), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
